// File: rtl/cache_pkg.sv
// Shared L1 cache definitions: refill FSM states, default line geometry, address helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DELIVER
    } refill_state_t;

    // Default cache geometry used by L1Cache and the refill unit.
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_LINE_WORDS = 4;

    localparam int unsigned LINE_BYTES  = DEF_LINE_WORDS * DEF_DATA_WIDTH / 8;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_BYTES);

    // Clears the byte-offset bits of an address; generic so non-default geometries can share it.
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned offset_bits);
        return addr & ~((64'd1 << offset_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/l1_refill_unit_if.sv
// Bundles the L1 miss request, memory burst and refill delivery channels of the refill unit.
interface l1_refill_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned LEN_WIDTH = $clog2(LINE_WORDS);

    // L1 miss request
    logic                             miss_valid;
    logic [ADDR_WIDTH-1:0]            miss_addr;
    logic                             miss_ready;
    logic                             busy;

    // Memory burst read
    logic                             mem_req;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [LEN_WIDTH-1:0]             mem_len;
    logic                             mem_gnt;
    logic                             mem_rvalid;
    logic [DATA_WIDTH-1:0]            mem_rdata;
    logic                             mem_err;

    // Line delivery to L1
    logic                             refill_valid;
    logic [ADDR_WIDTH-1:0]            refill_addr;
    logic [LINE_WORDS*DATA_WIDTH-1:0] refill_data;
    logic                             refill_err;
    logic                             refill_ready;

    // Environment view: L1 and main memory
    modport master (
        output miss_valid, miss_addr, mem_gnt, mem_rvalid, mem_rdata, mem_err, refill_ready,
        input  miss_ready, busy, mem_req, mem_addr, mem_len,
               refill_valid, refill_addr, refill_data, refill_err
    );

    // Refill unit view
    modport slave (
        input  miss_valid, miss_addr, mem_gnt, mem_rvalid, mem_rdata, mem_err, refill_ready,
        output miss_ready, busy, mem_req, mem_addr, mem_len,
               refill_valid, refill_addr, refill_data, refill_err
    );

endinterface

// File: rtl/l1_refill_unit_line_buffer.sv
// Line assembly buffer: LINE_WORDS words with indexed write, bulk clear and a flat line output.
module refill_line_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0]    wr_idx,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] line
);

    logic [DATA_WIDTH-1:0] words [LINE_WORDS];

    // Word storage: cleared on reset or at the start of a new refill, otherwise one word per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    // Flatten with word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
    always_comb begin
        line = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            line[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
        end
    end

endmodule

// File: rtl/l1_refill_unit.sv
// L1 miss handler: one outstanding miss, single burst read, line assembly and hand-back to L1.
module l1_refill_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input logic            clk,
    input logic            rst,
    l1_refill_unit_if.slave bus
);
    import cache_pkg::*;

    localparam int unsigned CNT_WIDTH   = $clog2(LINE_WORDS);
    localparam int unsigned LINE_OFFSET = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(LINE_WORDS - 1);

    refill_state_t          state;
    refill_state_t          state_next;
    logic [ADDR_WIDTH-1:0]  base;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   err;
    logic                   accept;
    logic                   beat;
    logic                   grant;

    // Next-state and event decode; beats and grants outside their state are simply not decoded.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        beat       = 1'b0;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.miss_valid) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    grant      = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (bus.mem_rvalid) begin
                    beat = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_next = DELIVER;
                    end
                end
            end
            DELIVER: begin
                if (bus.refill_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Line base, beat counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            if (accept) begin
                base <= ADDR_WIDTH'(line_base(64'(bus.miss_addr), LINE_OFFSET));
                err  <= 1'b0;
            end
            if (grant) begin
                cnt <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
                err <= err | bus.mem_err;
            end
        end
    end

    refill_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .wr_en   (beat),
        .wr_idx  (cnt),
        .wr_data (bus.mem_rdata),
        .line    (bus.refill_data)
    );

    // Handshake outputs decode straight from the state register.
    assign bus.miss_ready   = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.mem_req      = (state == REQ);
    assign bus.mem_addr     = base;
    assign bus.mem_len      = LAST_BEAT;
    assign bus.refill_valid = (state == DELIVER);
    assign bus.refill_addr  = base;
    assign bus.refill_err   = (state == DELIVER) && err;

endmodule

// File: tb/tb_l1_refill_unit.sv
// Self-checking bench for l1_refill_unit: directed scenarios plus randomized refills vs a line model.
module tb_l1_refill_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;
    localparam int unsigned LB = LW * DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    l1_refill_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) bus ();

    l1_refill_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miss_ready"},   bus.miss_ready, 1);
        check({tag, "_busy"},         bus.busy, 0);
        check({tag, "_mem_req"},      bus.mem_req, 0);
        check({tag, "_refill_valid"}, bus.refill_valid, 0);
        check({tag, "_refill_err"},   bus.refill_err, 0);
        check({tag, "_mem_addr"},     bus.mem_addr, 0);
        check({tag, "_refill_addr"},  bus.refill_addr, 0);
        check({tag, "_refill_data"},  bus.refill_data, 0);
    endtask

    // One complete refill. pre_miss: 0 none, 1 raise next miss at the handshake, 2 raise it from DELIVER start.
    task automatic run_miss(input string tag, input logic [31:0] addr, input logic [31:0] w [LW],
                            input logic [LW-1:0] errmask, input int gnt_dly, input int gap,
                            input int rdy_dly, input bit noisy, input int pre_miss,
                            input logic [31:0] next_addr, output int req_cyc, output int hs_cyc);
        logic [127:0] exp_data;
        logic [31:0]  base;
        int           start;
        base     = addr - (addr % LB);
        exp_data = '0;
        for (int i = 0; i < LW; i++) exp_data[i*DW +: DW] = w[i];

        check({tag, "_idle_ready"}, bus.miss_ready, 1);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = addr;
        start = cyc;
        @(negedge clk);
        bus.miss_valid = 1'b0;
        req_cyc = cyc;
        check({tag, "_mem_req"},   bus.mem_req, 1);
        check({tag, "_mem_addr"},  bus.mem_addr, base);
        check({tag, "_mem_len"},   bus.mem_len, LW - 1);
        check({tag, "_busy_req"},  bus.busy, 1);
        check({tag, "_ready_low"}, bus.miss_ready, 0);

        for (int k = 0; k < gnt_dly; k++) begin
            if (noisy) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = $urandom;
            end
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            check({tag, "_req_hold"},  bus.mem_req, 1);
            check({tag, "_addr_hold"}, bus.mem_addr, base);
            check({tag, "_busy_stall"}, bus.busy, 1);
        end

        bus.mem_gnt = 1'b1;
        if (noisy) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
        end
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        check({tag, "_req_drop"}, bus.mem_req, 0);

        for (int i = 0; i < LW; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check({tag, "_busy_fill"}, bus.busy, 1);
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = w[i];
            bus.mem_err    = errmask[i];
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_err    = 1'b0;
            if (i < LW - 1) check({tag, "_no_early_valid"}, bus.refill_valid, 0);
        end

        check({tag, "_latency"},     cyc - start, 2 + LW + gnt_dly + gap * LW);
        check({tag, "_valid"},       bus.refill_valid, 1);
        check({tag, "_refill_addr"}, bus.refill_addr, base);
        check({tag, "_refill_data"}, bus.refill_data, exp_data);
        check({tag, "_refill_err"},  bus.refill_err, |errmask);

        if (pre_miss == 2) begin
            bus.miss_valid = 1'b1;
            bus.miss_addr  = next_addr;
        end
        for (int k = 0; k < rdy_dly; k++) begin
            if (noisy) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = $urandom;
                bus.mem_err    = 1'b1;
            end
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_err    = 1'b0;
            check({tag, "_valid_hold"}, bus.refill_valid, 1);
            check({tag, "_data_hold"},  bus.refill_data, exp_data);
            check({tag, "_err_hold"},   bus.refill_err, |errmask);
            check({tag, "_no_accept"},  bus.miss_ready, 0);
        end

        bus.refill_ready = 1'b1;
        if (pre_miss == 1) begin
            bus.miss_valid = 1'b1;
            bus.miss_addr  = next_addr;
        end
        hs_cyc = cyc;
        @(negedge clk);
        bus.refill_ready = 1'b0;
        check({tag, "_valid_drop"}, bus.refill_valid, 0);
        check({tag, "_idle_busy"},  bus.busy, 0);
        check({tag, "_idle_mreq"},  bus.mem_req, 0);
    endtask

    initial begin
        logic [31:0] w [LW];
        int req_c, hs_c, prev_hs;
        bus.miss_valid   = 1'b0;
        bus.miss_addr    = '0;
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = '0;
        bus.mem_err      = 1'b0;
        bus.refill_ready = 1'b0;
        rst = 1'b0;

        // Power-on reset
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset asserted mid-FILL after two beats
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_0104;
        @(negedge clk);
        bus.miss_valid = 1'b0;
        bus.mem_gnt    = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hDEAD_0000 + i;
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        check("mid_fill_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hBAD0_0000 + i;
            bus.mem_err    = 1'b1;
            @(negedge clk);
            check("stray_beat_idle_ready", bus.miss_ready, 1);
            check("stray_beat_idle_busy",  bus.busy, 0);
            check("stray_beat_idle_data",  bus.refill_data, 0);
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_err    = 1'b0;

        // Zero-wait refill
        w = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_miss("zero_wait", 32'h0000_001C, w, 4'b0000, 0, 0, 0, 1'b0, 0, '0, req_c, hs_c);
        check("zero_wait_line", bus.refill_data, 128'h00000044_00000033_00000022_00000011);

        // Stalled memory with stray beats in REQ and DELIVER
        w = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'hD4D4_0004};
        run_miss("stalled", 32'h0000_0ABC, w, 4'b0000, 3, 2, 2, 1'b1, 0, '0, req_c, hs_c);

        // Bus error on beat 2, then a clean miss
        w = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_miss("bus_err", 32'h0000_0020, w, 4'b0100, 0, 0, 0, 1'b0, 0, '0, req_c, hs_c);
        w = '{32'h5, 32'h6, 32'h7, 32'h8};
        run_miss("after_err", 32'h0000_0024, w, 4'b0000, 1, 0, 0, 1'b0, 0, '0, req_c, hs_c);

        // Backpressure with a pending miss to 0x40 held through DELIVER
        w = '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
        run_miss("backpress", 32'h0000_0030, w, 4'b0000, 0, 1, 5, 1'b1, 2, 32'h0000_0040, req_c, hs_c);
        check("pending_not_taken_early", bus.miss_ready, 1);
        w = '{32'h4040_0000, 32'h4040_0001, 32'h4040_0002, 32'h4040_0003};
        run_miss("pending_0x40", 32'h0000_0040, w, 4'b0000, 0, 0, 1, 1'b0, 1, 32'h0000_0048, req_c, hs_c);
        prev_hs = hs_c;

        // Back-to-back miss to the same line: refetched, mem_req two cycles after the handshake
        w = '{32'h9000_0000, 32'h9000_0001, 32'h9000_0002, 32'h9000_0003};
        run_miss("b2b_same_line", 32'h0000_0048, w, 4'b0000, 0, 0, 0, 1'b0, 0, '0, req_c, hs_c);
        check("b2b_req_delay", req_c - prev_hs, 2);

        // Randomized refills checked against the line model
        for (int t = 0; t < 24; t++) begin
            logic [31:0]    a;
            logic [LW-1:0]  em;
            a  = $urandom;
            em = ($urandom_range(0, 3) == 0) ? LW'($urandom) : '0;
            for (int i = 0; i < LW; i++) w[i] = $urandom;
            run_miss("rand", a, w, em, $urandom_range(0, 3), $urandom_range(0, 2),
                     $urandom_range(0, 3), 1'($urandom), 0, '0, req_c, hs_c);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
